// File: rtl/plic_gateway.sv
// PLIC interrupt gateway and pending-register stage.
// Synchronizes raw interrupt lines, turns level/edge requests into one-shot
// pending bits for the priority resolver, tracks claim/complete so each source
// has at most one outstanding request, and buffers rising edges that arrive
// while a source is busy.
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   irq_src             raw asynchronous request lines
//   edge_mode           per source: 1 = rising edge, 0 = level-high
//   enable              per source enable (masks forwarding and claims)
//   claim, claim_id     claim strobe and claimed ID (source j has ID j+1)
//   complete, complete_id  completion strobe and completed ID
//   pending_interrupts  pending_raw & enable, to resolver (combinational)
//   pending_raw         unmasked pending bits
//   in_service          claimed and not yet completed
//   irq_any             OR of pending_interrupts (combinational)
module plic_gateway #(
  parameter int unsigned N_INTERRUPTS = 32,
  parameter int unsigned EDGE_CNT_W   = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [N_INTERRUPTS-1:0] irq_src,
  input  logic [N_INTERRUPTS-1:0] edge_mode,
  input  logic [N_INTERRUPTS-1:0] enable,
  input  logic                    claim,
  input  logic [31:0]             claim_id,
  input  logic                    complete,
  input  logic [31:0]             complete_id,
  output logic [N_INTERRUPTS-1:0] pending_interrupts,
  output logic [N_INTERRUPTS-1:0] pending_raw,
  output logic [N_INTERRUPTS-1:0] in_service,
  output logic                    irq_any
);

  localparam int unsigned ID_W = 32;
  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  // State is held directly in {in_service, pending_raw}; 2'b11 is illegal.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_PENDING    = 2'b01,
    ST_IN_SERVICE = 2'b10
  } state_e;

  logic [N_INTERRUPTS-1:0] sync_q;
  logic [N_INTERRUPTS-1:0] s_q;
  logic [N_INTERRUPTS-1:0] s_prev_q;
  logic [N_INTERRUPTS-1:0] rise;
  logic [N_INTERRUPTS-1:0] claim_hit;
  logic [N_INTERRUPTS-1:0] complete_hit;
  logic [N_INTERRUPTS-1:0] pending_d;
  logic [N_INTERRUPTS-1:0] in_service_d;
  logic [EDGE_CNT_W-1:0]   cnt_q   [N_INTERRUPTS];
  logic [EDGE_CNT_W-1:0]   cnt_d   [N_INTERRUPTS];
  logic [EDGE_CNT_W-1:0]   cnt_inc [N_INTERRUPTS];

  assign rise = s_q & ~s_prev_q;

  // ID decode; out-of-range IDs (0, > N_INTERRUPTS) match no source.
  for (genvar j = 0; j < N_INTERRUPTS; j++) begin : g_src
    assign claim_hit[j]    = claim    && (claim_id    == ID_W'(j + 1));
    assign complete_hit[j] = complete && (complete_id == ID_W'(j + 1));
    assign cnt_inc[j]      = (cnt_q[j] == CNT_MAX) ? CNT_MAX : cnt_q[j] + EDGE_CNT_W'(1);
  end

  // Synchronizers, edge history, per-source state and edge counters.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q      <= '0;
      s_q         <= '0;
      s_prev_q    <= '0;
      pending_raw <= '0;
      in_service  <= '0;
      for (int j = 0; j < N_INTERRUPTS; j++) cnt_q[j] <= '0;
    end else begin
      sync_q      <= irq_src;
      s_q         <= sync_q;
      s_prev_q    <= s_q;
      pending_raw <= pending_d;
      in_service  <= in_service_d;
      for (int j = 0; j < N_INTERRUPTS; j++) cnt_q[j] <= cnt_d[j];
    end
  end

  // Per-source next state and edge-counter update.
  always_comb begin
    pending_d    = pending_raw;
    in_service_d = in_service;
    for (int j = 0; j < N_INTERRUPTS; j++) cnt_d[j] = cnt_q[j];

    for (int j = 0; j < N_INTERRUPTS; j++) begin
      case (state_e'({in_service[j], pending_raw[j]}))
        ST_IDLE: begin
          if (edge_mode[j] ? rise[j] : s_q[j]) pending_d[j] = 1'b1;
        end
        ST_PENDING: begin
          if (edge_mode[j] && rise[j]) cnt_d[j] = cnt_inc[j];
          if (claim_hit[j] && enable[j]) begin
            pending_d[j]    = 1'b0;
            in_service_d[j] = 1'b1;
          end
        end
        ST_IN_SERVICE: begin
          if (edge_mode[j] && rise[j]) cnt_d[j] = cnt_inc[j];
          if (complete_hit[j]) begin
            in_service_d[j] = 1'b0;
            if (edge_mode[j] && (cnt_q[j] != '0)) begin
              // A same-cycle edge replaces the buffered one being consumed.
              pending_d[j] = 1'b1;
              cnt_d[j]     = rise[j] ? cnt_q[j] : cnt_q[j] - EDGE_CNT_W'(1);
            end else if (edge_mode[j] && rise[j]) begin
              pending_d[j] = 1'b1;
              cnt_d[j]     = '0;
            end
          end
        end
        default: begin
          // Illegal encoding: recover to IDLE.
          pending_d[j]    = 1'b0;
          in_service_d[j] = 1'b0;
        end
      endcase
      if (!edge_mode[j]) cnt_d[j] = '0;
    end
  end

  assign pending_interrupts = pending_raw & enable;
  assign irq_any            = |pending_interrupts;

endmodule

// File: tb/tb_plic_gateway.sv
// Scoreboard bench for plic_gateway: stimulus pushes hand-computed expected
// outputs tagged with the negedge at which they must hold; a monitor pops
// and compares at each negedge.
module tb_plic_gateway;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [N-1:0]  irq, em, en;
  logic          clm, cmp;
  logic [31:0]   cid, cpid;
  logic [N-1:0]  pending_interrupts, pending_raw, in_service;
  logic          irq_any;

  plic_gateway #(.N_INTERRUPTS(N), .EDGE_CNT_W(3)) dut (
    .clk(clk), .n_rst(n_rst), .irq_src(irq), .edge_mode(em), .enable(en),
    .claim(clm), .claim_id(cid), .complete(cmp), .complete_id(cpid),
    .pending_interrupts(pending_interrupts), .pending_raw(pending_raw),
    .in_service(in_service), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           tag;
    logic [N-1:0] pr;
    logic [N-1:0] ins;
    logic [N-1:0] pi;
    logic         any;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] e_pr, e_is;

  // Monitor: at each negedge pop every expectation due now and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.tag != cyc || pending_raw !== e.pr || in_service !== e.ins ||
            pending_interrupts !== e.pi || irq_any !== e.any) begin
          errors++;
          $display("FAIL %s: pending_raw=%h exp %h, in_service=%h exp %h, pending_interrupts=%h exp %h, irq_any=%b exp %b (cycle %0d due %0d)",
                   e.name, pending_raw, e.pr, in_service, e.ins, pending_interrupts, e.pi,
                   irq_any, e.any, cyc, e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expectation for the next negedge, i.e. after the next posedge.
  task automatic push(input string nm);
    exp_t e;
    e.name = nm;
    e.tag  = cyc + 1;
    e.pr   = e_pr;
    e.ins  = e_is;
    e.pi   = e_pr & en;
    e.any  = |(e_pr & en);
    sb.push_back(e);
  endtask

  task automatic chk(input string nm);
    push(nm);
    tick();
  endtask

  // One-cycle pulse; its rise is seen by the state flops on the caller's next edge.
  task automatic pulse(input logic [N-1:0] m);
    irq = irq | m;
    tick();
    irq = irq & ~m;
    tick();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    irq = '0; em = '0; en = '1;
    clm = 1'b0; cid = '0; cmp = 1'b0; cpid = '0;
    e_pr = '0; e_is = '0;
    chk("reset");
    n_rst = 1'b1;
    tick();
  endtask

  task automatic do_claim(input int id, input string nm);
    clm = 1'b1; cid = 32'(id);
    chk(nm);
    clm = 1'b0;
  endtask

  task automatic do_complete(input int id, input string nm);
    cmp = 1'b1; cpid = 32'(id);
    chk(nm);
    cmp = 1'b0;
  endtask

  initial begin
    // Level path on source 0.
    do_reset();
    irq[0] = 1'b1;
    chk("lvl_edge1");
    chk("lvl_edge2");
    e_pr[0] = 1'b1; chk("lvl_edge3");
    e_pr[0] = 1'b0; e_is[0] = 1'b1; do_claim(1, "lvl_claim");
    chk("lvl_hold");
    e_is[0] = 1'b0; do_complete(1, "lvl_complete_idle");
    e_pr[0] = 1'b1; chk("lvl_repend");

    // Edge buffering on source 5 (ID 6).
    do_reset();
    em[5] = 1'b1;
    pulse(32'h20); e_pr[5] = 1'b1; chk("edge_pend");
    e_pr[5] = 1'b0; e_is[5] = 1'b1; do_claim(6, "edge_claim");
    pulse(32'h20); chk("edge_buf1");
    pulse(32'h20); chk("edge_buf2");
    e_pr[5] = 1'b1; e_is[5] = 1'b0; do_complete(6, "edge_cmp1_repend");
    e_pr[5] = 1'b0; e_is[5] = 1'b1; do_claim(6, "edge_claim2");
    e_pr[5] = 1'b1; e_is[5] = 1'b0; do_complete(6, "edge_cmp2_repend");
    e_pr[5] = 1'b0; e_is[5] = 1'b1; do_claim(6, "edge_claim3");
    e_is[5] = 1'b0; do_complete(6, "edge_cmp3_idle");
    chk("edge_idle_hold");
    // Rise coinciding with a complete at counter 0 re-pends with counter 0.
    pulse(32'h20); e_pr[5] = 1'b1; chk("edge_pend2");
    e_pr[5] = 1'b0; e_is[5] = 1'b1; do_claim(6, "edge_claim4");
    pulse(32'h20);
    e_pr[5] = 1'b1; e_is[5] = 1'b0; do_complete(6, "edge_rise_cmp");
    e_pr[5] = 1'b0; e_is[5] = 1'b1; do_claim(6, "edge_claim5");
    e_is[5] = 1'b0; do_complete(6, "edge_cmp5_idle");

    // Saturation on source 3 (ID 4).
    do_reset();
    em[3] = 1'b1;
    pulse(32'h8); e_pr[3] = 1'b1; chk("sat_pend");
    e_pr[3] = 1'b0; e_is[3] = 1'b1; do_claim(4, "sat_claim");
    for (int i = 0; i < 10; i++) begin
      pulse(32'h8);
      tick();
    end
    chk("sat_hold");
    for (int k = 0; k < 7; k++) begin
      e_pr[3] = 1'b1; e_is[3] = 1'b0; do_complete(4, $sformatf("sat_cmp%0d", k));
      e_pr[3] = 1'b0; e_is[3] = 1'b1; do_claim(4, $sformatf("sat_clm%0d", k));
    end
    e_is[3] = 1'b0; do_complete(4, "sat_idle");
    chk("sat_idle_hold");

    // Enable masking on source 2 (ID 3).
    do_reset();
    en[2] = 1'b0;
    irq[2] = 1'b1;
    tick(); tick();
    e_pr[2] = 1'b1; chk("en_latched_masked");
    do_claim(3, "en_claim_ignored");
    @(posedge clk); #1;
    en[2] = 1'b1;
    push("en_comb_expose");
    tick();
    e_pr[2] = 1'b0; e_is[2] = 1'b1; do_claim(3, "en_claim_ok");
    en[2] = 1'b0;
    e_is[2] = 1'b0; do_complete(3, "en_disabled_complete");
    e_pr[2] = 1'b1; chk("en_disabled_repend");

    // Ignored operations.
    do_reset();
    irq[0] = 1'b1;
    tick(); tick();
    e_pr[0] = 1'b1; chk("ill_pend");
    do_claim(0, "ill_claim0");
    do_claim(33, "ill_claim33");
    do_claim(-1, "ill_claim_max");
    do_claim(2, "ill_claim_idle");
    do_complete(1, "ill_cmp_pending");
    // Same-ID claim and complete together: claim applies, complete ignored.
    clm = 1'b1; cid = 32'd1; cmp = 1'b1; cpid = 32'd1;
    e_pr[0] = 1'b0; e_is[0] = 1'b1; chk("ill_claim_cmp_same");
    clm = 1'b0; cmp = 1'b0;

    // Asynchronous reset while sources 0 and 7 are in service with buffered edges.
    do_reset();
    em[0] = 1'b1; em[7] = 1'b1;
    pulse(32'h81); e_pr = 32'h81; chk("ar_pend");
    e_pr[0] = 1'b0; e_is[0] = 1'b1; do_claim(1, "ar_claim0");
    e_pr[7] = 1'b0; e_is[7] = 1'b1; do_claim(8, "ar_claim7");
    pulse(32'h81); chk("ar_buffered");
    @(posedge clk); #2;
    n_rst = 1'b0;
    e_pr = '0; e_is = '0;
    push("ar_async_clear");
    tick();
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) chk($sformatf("ar_quiet%0d", i));
    pulse(32'h80); e_pr[7] = 1'b1; chk("ar_new_pend");
    e_pr[7] = 1'b0; e_is[7] = 1'b1; do_claim(8, "ar_claim_new");
    e_is[7] = 1'b0; do_complete(8, "ar_cmp_idle");
    chk("ar_idle_hold");

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
